// File: rtl/tdc_accum_readout.sv
// tdc_accum_readout
//   Capture, averaging and readout stage behind a tapped TDC delay line.
//   Each hit samples the thermometer word; its popcount is optionally
//   averaged over 1/2/4/8 hits, tagged with a sequence number and queued in
//   a small FIFO that the host reads one byte at a time.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous reset, active-high
//   therm     delay-line taps (already synchronous to clk)
//   hit       1-cycle strobe: sample therm
//   mode      0 = single-shot, 1 = accumulate
//   avg_sel   accumulate group size = 1 << avg_sel
//   rd_pop    1-cycle strobe: pop FIFO head
//   byte_sel  0 = result byte, 1 = sequence byte
//   clr_ovf   clear sticky overflow
//   dout      selected byte of FIFO head, 0 when empty
//   empty     FIFO empty
//   full      FIFO full
//   overflow  sticky: a completed group was dropped
//   level     FIFO occupancy
//
// Accumulate FSM
//   state | meaning
//   IDLE  | no group open; next count opens a group (or is pushed directly
//         | when the group size is 1)
//   ACCUM | group open; acc holds the partial sum, n counts accepted hits
//
//   The push of a finished group happens in the same cycle its last count is
//   consumed (result taken from acc + count). That keeps single-shot latency
//   at hit -> FIFO write two edges later, and a count following a completed
//   group lands in IDLE and opens the next group without loss.

module tdc_accum_readout #(
  parameter int N_DELAY    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_DELAY-1:0]            therm,
  input  logic                          hit,
  input  logic                          mode,
  input  logic [1:0]                    avg_sel,
  input  logic                          rd_pop,
  input  logic                          byte_sel,
  input  logic                          clr_ovf,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CNT_W = $clog2(N_DELAY + 1);
  localparam int ACC_W = CNT_W + 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_DELAY-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_DELAY; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Blocks a hit that coincides with reset release.
  logic               rst_dly_q;
  logic               s1_v_q;
  logic [N_DELAY-1:0] s1_therm_q;
  logic               s2_v_q;
  logic [CNT_W-1:0]   s2_cnt_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rst_dly_q  <= 1'b1;
      s1_v_q     <= 1'b0;
      s1_therm_q <= '0;
      s2_v_q     <= 1'b0;
      s2_cnt_q   <= '0;
    end else begin
      rst_dly_q <= 1'b0;
      s1_v_q    <= hit & ~rst_dly_q;
      if (hit & ~rst_dly_q) s1_therm_q <= therm;
      s2_v_q    <= s1_v_q;
      if (s1_v_q) s2_cnt_q <= popcnt(s1_therm_q);
    end
  end

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [3:0]       n_q;
  logic [1:0]       g_avg_q;
  logic [7:0]       seq_q;

  logic [1:0]       avg_new;
  logic [ACC_W-1:0] cnt_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] shifted;
  logic [3:0]       n_next;
  logic [3:0]       grp_sz;
  logic             push;
  logic [7:0]       res8;

  always_comb begin
    avg_new = mode ? avg_sel : 2'd0;
    cnt_ext = ACC_W'(s2_cnt_q);
    sum     = acc_q + cnt_ext;
    n_next  = n_q + 4'd1;
    grp_sz  = 4'd1 << g_avg_q;
    push    = 1'b0;
    shifted = '0;
    if (s2_v_q) begin
      if (state_q == IDLE) begin
        if (avg_new == 2'd0) begin
          push    = 1'b1;
          shifted = cnt_ext;
        end
      end else if (n_next == grp_sz) begin
        push    = 1'b1;
        shifted = sum >> g_avg_q;
      end
    end
    res8 = 8'(shifted);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      g_avg_q <= '0;
      seq_q   <= '0;
    end else begin
      if (push) seq_q <= seq_q + 8'd1;
      if (s2_v_q) begin
        case (state_q)
          IDLE: begin
            if (avg_new != 2'd0) begin
              state_q <= ACCUM;
              acc_q   <= cnt_ext;
              n_q     <= 4'd1;
              g_avg_q <= avg_new;
            end
          end
          ACCUM: begin
            if (push) begin
              state_q <= IDLE;
              acc_q   <= '0;
              n_q     <= '0;
            end else begin
              acc_q <= sum;
              n_q   <= n_next;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [15:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_q, rd_q;
  logic [15:0]  head;
  logic         pop_en, wr_en, drop, overflow_d;

  always_comb begin
    level  = wr_q - rd_q;
    empty  = (level == '0);
    full   = (level == (PTR_W + 1)'(FIFO_DEPTH));
    pop_en = rd_pop & ~empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    wr_en  = push & (~full | pop_en);
    drop   = push & ~wr_en;
    overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
    head   = mem_q[rd_q[PTR_W-1:0]];
    dout   = empty ? 8'd0 : (byte_sel ? head[15:8] : head[7:0]);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      overflow <= overflow_d;
      if (wr_en) begin
        mem_q[wr_q[PTR_W-1:0]] <= {seq_q, res8};
        wr_q <= wr_q + 1'b1;
      end
      if (pop_en) rd_q <= rd_q + 1'b1;
    end
  end

endmodule
